// File: rtl/pwm_compare_if.sv
// -----------------------------------------------------------------------------
// pwm_compare_if
//   Duty-write handshake between a duty source and pwm_compare.
//   A write is accepted on a cycle where wr_valid & wr_ready are both high.
// Signals
//   wr_valid  master->slave  1       duty write request
//   wr_duty   master->slave  SIZE+1  requested duty in counter steps
//   wr_ready  slave->master  1       slave can accept a write this cycle
// Modports
//   master : duty source
//   slave  : pwm_compare
// -----------------------------------------------------------------------------
interface pwm_compare_if #(
  parameter int SIZE = 8
);
  logic            wr_valid;
  logic            wr_ready;
  logic [SIZE:0]   wr_duty;

  modport master (output wr_valid, output wr_duty, input wr_ready);
  modport slave  (input wr_valid, input wr_duty, output wr_ready);
endinterface

// File: rtl/pwm_compare.sv
// -----------------------------------------------------------------------------
// pwm_compare
//   Consumer of an external free-running up-counter. Compares the counter value
//   against a double-buffered duty register and produces a registered PWM
//   output, a compare-match pulse and a period-wrap pulse. New duty values are
//   parked in a single pending slot and only become active at a period
//   boundary, so every PWM period is glitch-free.
//
// Parameters
//   SIZE      counter width; one period is 2**SIZE counter steps
//
// Ports
//   clk       in   1       clock, rising edge
//   rst       in   1       asynchronous reset, active-high
//   cnt       in   SIZE    counter value from the upstream counter
//   cnt_ena   in   1       counter advances on this cycle
//   wr        slave        duty write handshake (wr_valid/wr_ready/wr_duty)
//   pwm       out  1       registered PWM output
//   match     out  1       one-cycle pulse on compare match
//   wrap      out  1       one-cycle pulse at period end
//   duty_act  out  SIZE+1  duty currently in effect
//   irq_clr   in   1       (PWM_IRQ_EN only) clears the sticky irq
//   irq       out  1       (PWM_IRQ_EN only) set when a pending duty is applied
//
// Configuration
//   PWM_IRQ_EN  when defined, adds irq/irq_clr and the sticky transfer flag.
// -----------------------------------------------------------------------------
module pwm_compare #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] cnt,
  input  logic            cnt_ena,
  pwm_compare_if.slave    wr,
  output logic            pwm,
  output logic            match,
  output logic            wrap,
`ifdef PWM_IRQ_EN
  input  logic            irq_clr,
  output logic            irq,
`endif
  output logic [SIZE:0]   duty_act
);

  localparam logic [SIZE:0]   DUTY_MAX = {1'b1, {SIZE{1'b0}}};
  localparam logic [SIZE-1:0] CNT_LAST = {SIZE{1'b1}};

  logic          pend_full;
  logic [SIZE:0] pend_duty;
  logic [SIZE:0] wr_duty_sat;
  logic          wr_fire;
  logic          wrap_ev;
  logic          xfer;
  logic [SIZE:0] cnt_ext;

  assign cnt_ext     = {1'b0, cnt};
  assign wr.wr_ready = ~pend_full;
  assign wr_fire     = wr.wr_valid & ~pend_full;
  assign wr_duty_sat = (wr.wr_duty > DUTY_MAX) ? DUTY_MAX : wr.wr_duty;

  // Last counter step of the period: the counter rolls over on this edge.
  assign wrap_ev = cnt_ena & (cnt == CNT_LAST);
  assign xfer    = wrap_ev & pend_full;

  // Pending slot and active duty. A write can only be accepted while the slot
  // is empty, so it never collides with a transfer on the same edge; a write
  // landing on the wrap cycle itself waits for the following wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking (<=) for every register so all state updates see
      // the pre-edge values, independent of statement order.
      pend_full <= 1'b0;
      // NOTE: pend_duty is only read while pend_full is set, but it is reset
      // anyway so duty_act can never pick up an X after an unusual sequence.
      pend_duty <= '0;
      duty_act  <= '0;
    end else if (xfer) begin
      duty_act  <= pend_duty;
      pend_full <= 1'b0;
    end else if (wr_fire) begin
      pend_duty <= wr_duty_sat;
      pend_full <= 1'b1;
    end
  end

  // Outputs. The compare runs every cycle, so a held counter holds pwm;
  // match and wrap are gated by cnt_ena so they pulse once per counter step.
  // Duty 2**SIZE is unreachable by the counter and therefore never matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm   <= 1'b0;
      match <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      pwm   <= (cnt_ext < duty_act);
      match <= cnt_ena & (cnt_ext == duty_act);
      wrap  <= wrap_ev;
    end
  end

`ifdef PWM_IRQ_EN
  // Sticky transfer flag; a new transfer wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (xfer) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_compare.sv
// -----------------------------------------------------------------------------
// tb_pwm_compare
//   Self-checking bench for pwm_compare with SIZE=4. The bench plays the
//   upstream counter itself and keeps a queue-based reference model of the
//   pending slot and active duty. Directed scenarios cover the documented
//   corner cases; a randomized phase follows. Build with +define+PWM_IRQ_EN to
//   include the irq checks.
// -----------------------------------------------------------------------------
module tb_pwm_compare;

  localparam int SIZE = 4;
  localparam int FULL = 1 << SIZE;

  logic            clk = 1'b0;
  logic            rst;
  logic [SIZE-1:0] cnt;
  logic            cnt_ena;
  logic            pwm;
  logic            match;
  logic            wrap;
  logic [SIZE:0]   duty_act;
`ifdef PWM_IRQ_EN
  logic            irq_clr;
  logic            irq;
`endif

  pwm_compare_if #(.SIZE(SIZE)) wr_if ();

  pwm_compare #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt),
    .cnt_ena  (cnt_ena),
    .wr       (wr_if.slave),
    .pwm      (pwm),
    .match    (match),
    .wrap     (wrap),
`ifdef PWM_IRQ_EN
    .irq_clr  (irq_clr),
    .irq      (irq),
`endif
    .duty_act (duty_act)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_act;
  int m_q[$];
  int m_pwm;
  int m_match;
  int m_wrap;
  int m_irq;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_outputs();
    check("pwm",      int'(pwm),      m_pwm);
    check("match",    int'(match),    m_match);
    check("wrap",     int'(wrap),     m_wrap);
    check("duty_act", int'(duty_act), m_act);
    check("wr_ready", int'(wr_if.wr_ready), (m_q.size() == 0) ? 1 : 0);
`ifdef PWM_IRQ_EN
    check("irq",      int'(irq),      m_irq);
`endif
  endtask

  // One clock: predict from the inputs present at the edge, clock, advance
  // the bench counter, compare. Inputs change only around the falling edge.
  task automatic tick();
    bit wev;
    bit fire;
    bit xfer;
    int c;
    c    = int'(cnt);
    wev  = cnt_ena && (c == FULL - 1);
    fire = wr_if.wr_valid && (m_q.size() == 0);
    xfer = wev && (m_q.size() > 0);
    m_pwm   = (c < m_act) ? 1 : 0;
    m_match = (cnt_ena && c == m_act) ? 1 : 0;
    m_wrap  = wev ? 1 : 0;
    if (xfer) m_act = m_q.pop_front();
    if (fire) m_q.push_back((int'(wr_if.wr_duty) > FULL) ? FULL : int'(wr_if.wr_duty));
`ifdef PWM_IRQ_EN
    if (xfer) m_irq = 1;
    else if (irq_clr) m_irq = 0;
`endif
    @(posedge clk);
    @(negedge clk);
    if (cnt_ena) cnt = cnt + 1'b1;
    check_outputs();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    wr_if.wr_valid = 1'b0;
    cnt = '0;
    #1;
    m_act = 0; m_q.delete(); m_pwm = 0; m_match = 0; m_wrap = 0; m_irq = 0;
    check_outputs();
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to(input int target);
    bit hit;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      if (int'(cnt) == target) begin
        hit = 1;
        break;
      end
      tick();
    end
    if (!hit) check("run_to_timeout", int'(cnt), target);
  endtask

  task automatic do_write(input int d);
    bit accepted;
    bit done;
    done = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_duty  = (SIZE+1)'(d);
    for (int i = 0; i < 40; i++) begin
      accepted = wr_if.wr_ready;
      tick();
      if (accepted) begin
        done = 1;
        break;
      end
    end
    wr_if.wr_valid = 1'b0;
    if (!done) check("write_timeout", 0, 1);
  endtask

  task automatic period_stats(input int n, output int hi, output int mt, output int wp);
    hi = 0; mt = 0; wp = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      hi += int'(pwm);
      mt += int'(match);
      wp += int'(wrap);
    end
  endtask

  initial begin
    int hi, mt, wp;
    int held_pwm;
    rst = 1'b0;
    cnt = '0;
    cnt_ena = 1'b1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_duty  = '0;
`ifdef PWM_IRQ_EN
    irq_clr = 1'b0;
`endif

    // Reset for 3 cycles, then idle outputs.
    do_reset(3);
    check("rst_pwm",      int'(pwm),      0);
    check("rst_duty_act", int'(duty_act), 0);
    check("rst_wr_ready", int'(wr_if.wr_ready), 1);
    tick();

    // Duty 5 written mid-period; applied only after 15->0.
    run_to(6);
    do_write(5);
    check("pend_ready_low", int'(wr_if.wr_ready), 0);
    check("duty_before_wrap", int'(duty_act), 0);
    run_to(0);
    check("duty5_applied", int'(duty_act), 5);
    period_stats(16, hi, mt, wp);
    check("duty5_high", hi, 5);
    check("duty5_match", mt, 1);
    check("duty5_wrap", wp, 1);

    // Duty 16 then 0: constant high period without match, then constant low.
    run_to(4);
    do_write(16);
    do_write(0);
    check("duty16_applied", int'(duty_act), 16);
    period_stats(15, hi, mt, wp);
    check("duty16_high", hi, 15);
    check("duty16_match", mt, 0);
    check("duty0_applied", int'(duty_act), 0);
    period_stats(16, hi, mt, wp);
    check("duty0_high", hi, 0);
    check("duty0_match", mt, 1);

    // Saturation: 20 captured as 16.
    run_to(3);
    do_write(20);
    run_to(0);
    check("sat_duty", int'(duty_act), 16);

    // Write on the wrap cycle: captured, applied one period later.
    run_to(15);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_duty  = 5'd7;
    tick();
    wr_if.wr_valid = 1'b0;
    check("wrapwr_not_applied", int'(duty_act), 16);
    check("wrapwr_pending", int'(wr_if.wr_ready), 0);

    // Counter stall for 4 cycles mid-period: outputs frozen.
    run_to(6);
    held_pwm = int'(pwm);
    cnt_ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_pwm", int'(pwm), held_pwm);
      check("stall_match", int'(match), 0);
      check("stall_wrap", int'(wrap), 0);
    end
    cnt_ena = 1'b1;
    run_to(0);
    check("wrapwr_applied", int'(duty_act), 7);

`ifdef PWM_IRQ_EN
    // irq set on transfer, cleared by irq_clr, set wins over clear.
    check("irq_after_xfer", int'(irq), 1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("irq_cleared", int'(irq), 0);
    do_write(9);
    run_to(15);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("irq_set_wins", int'(irq), 1);
`endif

    // Reset while a duty is pending at cnt=9: pending is discarded.
    run_to(2);
    do_write(3);
    run_to(9);
    do_reset(2);
    check("rst_pend_lost", int'(wr_if.wr_ready), 1);
    check("rst_duty_zero", int'(duty_act), 0);
    tick();

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      cnt_ena        = ($urandom_range(0, 7) != 0);
      wr_if.wr_valid = ($urandom_range(0, 3) == 0);
      wr_if.wr_duty  = (SIZE+1)'($urandom_range(0, 31));
`ifdef PWM_IRQ_EN
      irq_clr        = ($urandom_range(0, 5) == 0);
`endif
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
